// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Latency: WIDTH+1 edges from the accepted start to the done pulse (17 for WIDTH=16).
// Backpressure: none; start is only sampled in IDLE and ignored while busy, with no queueing.
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   start  request a conversion (sampled only when idle)
//   bin    binary operand, captured on the edge that accepts start
//   busy   high while a conversion is in progress
//   done   one-cycle pulse when bcd (and sign) update
//   bcd    packed BCD result, digit 0 (units) in bits [3:0], held until next completion
//   sign   result sign, present only when BIN2BCD_SIGNED_EN is defined
//
// Optional feature: define BIN2BCD_SIGNED_EN to treat bin as two's complement;
// the magnitude is converted and the sign is reported on the sign port.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                  sign
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] bin_r;
  logic [SW-1:0]    scratch;
  logic [CW-1:0]    cnt;

  logic [SW-1:0]       corrected;
  logic [SW+WIDTH-1:0] shifted;
  logic [WIDTH-1:0]    operand;

`ifdef BIN2BCD_SIGNED_EN
  logic sign_r;

  // Negating the most negative value wraps back to 2^(WIDTH-1), which is
  // exactly the magnitude we want when read as unsigned.
  assign operand = bin[WIDTH-1] ? (~bin + WIDTH'(1)) : bin;
`else
  assign operand = bin;
`endif

  // Every digit is corrected from the pre-shift value; a digit of 5..9 becomes
  // 8..12 so that the following shift carries into the next digit correctly.
  always_comb begin
    corrected = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        corrected[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // The MSB of bin_r moves into scratch bit 0 as the pair shifts left.
  assign shifted = {corrected, bin_r} << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      bin_r   <= '0;
      scratch <= '0;
      cnt     <= '0;
`ifdef BIN2BCD_SIGNED_EN
      sign_r  <= 1'b0;
      sign    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_r   <= operand;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            busy    <= 1'b1;
            state   <= SHIFT;
`ifdef BIN2BCD_SIGNED_EN
            sign_r  <= bin[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          scratch <= shifted[SW+WIDTH-1:WIDTH];
          bin_r   <= shifted[WIDTH-1:0];
          cnt     <= cnt - CW'(1);
          // Last bit: publish the freshly shifted scratch, not the stale register.
          if (cnt == CW'(1)) begin
            bcd   <= shifted[SW+WIDTH-1:WIDTH];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef BIN2BCD_SIGNED_EN
            sign  <= sign_r;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
